mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single delayed memory; each port holds one pending request.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin contention, otherwise port 0 has fixed priority.
module mem_arbiter #(
   parameter int unsigned addr_width = 32,
   parameter int unsigned data_width = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  p0_rd_req_i,
   input  logic                  p0_wr_req_i,
   input  logic [addr_width-1:0] p0_addr_i,
   input  logic [data_width-1:0] p0_wr_data_i,
   output logic [data_width-1:0] p0_rd_data_o,
   output logic                  p0_busy_o,
   output logic                  p0_ack_o,
   input  logic                  p1_rd_req_i,
   input  logic                  p1_wr_req_i,
   input  logic [addr_width-1:0] p1_addr_i,
   input  logic [data_width-1:0] p1_wr_data_i,
   output logic [data_width-1:0] p1_rd_data_o,
   output logic                  p1_busy_o,
   output logic                  p1_ack_o,
   output logic                  mem_rd_req_o,
   output logic                  mem_wr_req_o,
   output logic [addr_width-1:0] mem_addr_o,
   output logic [data_width-1:0] mem_wr_data_o,
   input  logic [data_width-1:0] mem_rd_data_i,
   input  logic                  mem_busy_i,
   input  logic                  mem_ack_i
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  mem_is_wr_q, mem_is_wr_d;
   logic [addr_width-1:0] mem_addr_q, mem_addr_d;
   logic [data_width-1:0] mem_wr_data_q, mem_wr_data_d;
   logic [data_width-1:0] rd_data_q, rd_data_d;

   logic [1:0]            pend_q, pend_d;
   logic [1:0]            slot_wr_q, slot_wr_d;
   logic [addr_width-1:0] slot_addr_q [2];
   logic [addr_width-1:0] slot_addr_d [2];
   logic [data_width-1:0] slot_wdata_q [2];
   logic [data_width-1:0] slot_wdata_d [2];

   logic [1:0]            req_rd, req_wr, accept, busy, resp;
   logic [addr_width-1:0] req_addr [2];
   logic [data_width-1:0] req_wdata [2];
   logic                  win;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic                  prio_q, prio_d;
`endif

   logic unused_mem_busy;
   assign unused_mem_busy = mem_busy_i;

   assign req_rd       = {p1_rd_req_i, p0_rd_req_i};
   assign req_wr       = {p1_wr_req_i, p0_wr_req_i};
   assign req_addr[0]  = p0_addr_i;
   assign req_addr[1]  = p1_addr_i;
   assign req_wdata[0] = p0_wr_data_i;
   assign req_wdata[1] = p1_wr_data_i;

   assign resp[0] = (state_q == StResp) && !grant_q;
   assign resp[1] = (state_q == StResp) && grant_q;
   // The slot being answered this cycle is free, so a fresh request may land in it.
   assign busy    = pend_q & ~resp;
   assign accept  = (req_rd | req_wr) & ~busy;

   always_comb begin
      pend_d       = pend_q & ~resp;
      slot_wr_d    = slot_wr_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      for (int p = 0; p < 2; p++) begin
         if (accept[p]) begin
            pend_d[p]       = 1'b1;
            slot_wr_d[p]    = req_wr[p];
            slot_addr_d[p]  = req_addr[p];
            slot_wdata_d[p] = req_wr[p] ? req_wdata[p] : '0;
         end
      end
   end

   always_comb begin
      if (&pend_q) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         win = prio_q;
`else
         win = 1'b0;
`endif
      end else begin
         win = pend_q[1];
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      mem_is_wr_d   = mem_is_wr_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      rd_data_d     = rd_data_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      prio_d        = prio_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (|pend_q) begin
               grant_d       = win;
               mem_is_wr_d   = slot_wr_q[win];
               mem_addr_d    = slot_addr_q[win];
               mem_wr_data_d = slot_wdata_q[win];
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
               prio_d        = ~win;
`endif
               state_d       = StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (mem_ack_i) begin
               rd_data_d = mem_is_wr_q ? '0 : mem_rd_data_i;
               state_d   = StResp;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         grant_q       <= 1'b0;
         mem_is_wr_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         rd_data_q     <= '0;
         pend_q        <= '0;
         slot_wr_q     <= '0;
         slot_addr_q   <= '{default: '0};
         slot_wdata_q  <= '{default: '0};
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         prio_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         mem_is_wr_q   <= mem_is_wr_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         rd_data_q     <= rd_data_d;
         pend_q        <= pend_d;
         slot_wr_q     <= slot_wr_d;
         slot_addr_q   <= slot_addr_d;
         slot_wdata_q  <= slot_wdata_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         prio_q        <= prio_d;
`endif
      end
   end

   assign mem_rd_req_o  = (state_q == StIssue) && !mem_is_wr_q;
   assign mem_wr_req_o  = (state_q == StIssue) && mem_is_wr_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_wr_data_o = mem_wr_data_q;

   assign p0_ack_o     = resp[0];
   assign p1_ack_o     = resp[1];
   assign p0_busy_o    = busy[0];
   assign p1_busy_o    = busy[1];
   assign p0_rd_data_o = resp[0] ? rd_data_q : '0;
   assign p1_rd_data_o = resp[1] ? rd_data_q : '0;

`ifndef SYNTHESIS
   a_p0_req_busy: assert property (@(posedge clk_i) disable iff (rst_i)
      !((p0_rd_req_i || p0_wr_req_i) && p0_busy_o))
      else $error("p0 request ignored while busy");
   a_p1_req_busy: assert property (@(posedge clk_i) disable iff (rst_i)
      !((p1_rd_req_i || p1_wr_req_i) && p1_busy_o))
      else $error("p1 request ignored while busy");
   a_stray_ack: assert property (@(posedge clk_i) disable iff (rst_i)
      !(mem_ack_i && (state_q != StWait)))
      else $error("mem_ack ignored outside WAIT");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a 4-cycle request-to-ack memory model.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
   logic [AW-1:0] p0_addr, p1_addr, mem_addr;
   logic [DW-1:0] p0_wr_data, p1_wr_data, p0_rd_data, p1_rd_data;
   logic          p0_busy, p0_ack, p1_busy, p1_ack;
   logic          mem_rd_req, mem_wr_req, mem_busy, mem_ack;
   logic [DW-1:0] mem_wr_data, mem_rd_data;

   mem_arbiter #(.addr_width(AW), .data_width(DW)) dut (
      .clk_i(clk), .rst_i(rst),
      .p0_rd_req_i(p0_rd_req), .p0_wr_req_i(p0_wr_req), .p0_addr_i(p0_addr),
      .p0_wr_data_i(p0_wr_data), .p0_rd_data_o(p0_rd_data), .p0_busy_o(p0_busy),
      .p0_ack_o(p0_ack),
      .p1_rd_req_i(p1_rd_req), .p1_wr_req_i(p1_wr_req), .p1_addr_i(p1_addr),
      .p1_wr_data_i(p1_wr_data), .p1_rd_data_o(p1_rd_data), .p1_busy_o(p1_busy),
      .p1_ack_o(p1_ack),
      .mem_rd_req_o(mem_rd_req), .mem_wr_req_o(mem_wr_req), .mem_addr_o(mem_addr),
      .mem_wr_data_o(mem_wr_data), .mem_rd_data_i(mem_rd_data), .mem_busy_i(mem_busy),
      .mem_ack_i(mem_ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Memory model: ack D cycles after the request cycle, dropped by reset.
   logic [DW-1:0] mem_arr [256];
   int            mcnt = 0;
   logic          mwr;
   logic [AW-1:0] maddr;

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = '0;
      mem_arr[8'h10] = 32'h1234;
   end

   assign mem_busy = (mcnt != 0);

   always @(posedge clk) begin
      mem_ack     <= 1'b0;
      mem_rd_data <= '0;
      if (rst) begin
         mcnt <= 0;
      end else begin
         if (mcnt != 0) begin
            if (mcnt == 1) begin
               mem_ack <= 1'b1;
               if (!mwr) mem_rd_data <= mem_arr[maddr[9:2]];
            end
            mcnt <= mcnt - 1;
         end
         if (mem_rd_req || mem_wr_req) begin
            mcnt  <= D - 1;
            mwr   <= mem_wr_req;
            maddr <= mem_addr;
            if (mem_wr_req) mem_arr[mem_addr[9:2]] <= mem_wr_data;
         end
      end
   end

   // Scoreboard: expected read data per port, pushed on drive, popped on ack.
   logic [DW-1:0] exp_q0 [$];
   logic [DW-1:0] exp_q1 [$];
   int            last_req_cyc = -100;
   logic          last_rd, last_wr;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_wdata;
   int            req_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (p0_ack) begin
            if (exp_q0.size() == 0) check("p0 ack without request", p0_ack, 0);
            else check("p0 rd_data", p0_rd_data, exp_q0.pop_front());
         end else check("p0 idle rd_data", p0_rd_data, 0);
         if (p1_ack) begin
            if (exp_q1.size() == 0) check("p1 ack without request", p1_ack, 0);
            else check("p1 rd_data", p1_rd_data, exp_q1.pop_front());
         end else check("p1 idle rd_data", p1_rd_data, 0);
         if (mem_rd_req || mem_wr_req) begin
            if (mem_rd_req && mem_wr_req) check("mem rd and wr together", mem_rd_req, 0);
            last_req_cyc = cyc;
            last_rd      = mem_rd_req;
            last_wr      = mem_wr_req;
            last_addr    = mem_addr;
            last_wdata   = mem_wr_data;
            req_cnt++;
         end
      end
   end

   task automatic drive(input bit port, input bit rd, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
      if (!port) begin
         p0_rd_req = rd; p0_wr_req = wr; p0_addr = addr; p0_wr_data = wdata;
         exp_q0.push_back(exp);
      end else begin
         p1_rd_req = rd; p1_wr_req = wr; p1_addr = addr; p1_wr_data = wdata;
         exp_q1.push_back(exp);
      end
   endtask

   task automatic release_reqs();
      p0_rd_req = 1'b0; p0_wr_req = 1'b0; p1_rd_req = 1'b0; p1_wr_req = 1'b0;
   endtask

   task automatic wait_ack(input bit port, input int from_cyc, output int lat);
      lat = -1;
      for (int i = 0; i < 60; i++) begin
         if ((port ? p1_ack : p0_ack) === 1'b1) begin
            lat = cyc - from_cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      bit            port;
      bit            rd;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #100000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int t, t2, lat, a0, a1, first_port, exp_first, rc;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h40,  32'h0,        32'h1234};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h80,  32'hBEEF,     32'h0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h80,  32'h0,        32'hBEEF};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h100, 32'hCAFE,     32'h0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        32'hCAFE};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h200, 32'h0,        32'h0};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, 32'h0};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        32'hFFFFFFFF};

      // Reset held two cycles with requests that must be dropped.
      rst = 1'b1;
      p0_addr = 32'h40; p0_wr_data = '0; p1_addr = 32'h80; p1_wr_data = 32'h77;
      p0_rd_req = 1'b1; p0_wr_req = 1'b0; p1_rd_req = 1'b0; p1_wr_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      release_reqs();
      rc = req_cnt;
      for (int i = 0; i < 5; i++) begin
         check("reset flags", {p0_ack, p1_ack, p0_busy, p1_busy, mem_rd_req, mem_wr_req}, 0);
         check("reset mem bus", {mem_addr, mem_wr_data}, 0);
         @(negedge clk);
      end
      check("no mem req after reset", req_cnt - rc, 0);

      // Uncontended table vectors.
      for (int i = 0; i < 8; i++) begin
         t = cyc;
         drive(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
         @(negedge clk);
         release_reqs();
         check($sformatf("v%0d busy after capture", i), vecs[i].port ? p1_busy : p0_busy, 1);
         wait_ack(vecs[i].port, t, lat);
         check($sformatf("v%0d ack latency", i), lat, 3 + D);
         check($sformatf("v%0d mem req cycle", i), last_req_cyc - t, 2);
         check($sformatf("v%0d mem req kind", i), {last_rd, last_wr},
               {vecs[i].rd & ~vecs[i].wr, vecs[i].wr});
         check($sformatf("v%0d mem addr", i), last_addr, vecs[i].addr);
         if (vecs[i].wr) check($sformatf("v%0d mem wdata", i), last_wdata, vecs[i].wdata);
         check($sformatf("v%0d busy at ack", i), vecs[i].port ? p1_busy : p0_busy, 0);
         @(negedge clk);
      end

      // New request accepted during the port's own RESP cycle.
      t = cyc;
      drive(1'b1, 1'b0, 1'b1, 32'h84, 32'hBEEF, 32'h0);
      @(negedge clk);
      release_reqs();
      wait_ack(1'b1, t, lat);
      check("resp chain write latency", lat, 3 + D);
      check("resp chain busy in RESP", p1_busy, 0);
      t2 = cyc;
      drive(1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 32'hBEEF);
      @(negedge clk);
      release_reqs();
      check("resp chain busy after capture", p1_busy, 1);
      wait_ack(1'b1, t2, lat);
      check("resp chain read latency", lat, 3 + D);
      @(negedge clk);

      // Solo p0 grant so round-robin and fixed priority diverge on the next contention.
      t = cyc;
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1234);
      @(negedge clk);
      release_reqs();
      wait_ack(1'b0, t, lat);
      check("solo p0 latency", lat, 3 + D);
      @(negedge clk);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_first = 1;
`else
      exp_first = 0;
`endif
      for (int k = 0; k < 4; k++) begin
         t = cyc;
         drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1234);
         drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 32'hBEEF);
         @(negedge clk);
         release_reqs();
         check($sformatf("pair%0d both busy", k), {p1_busy, p0_busy}, 2'b11);
         a0 = -1;
         a1 = -1;
         for (int i = 0; i < 60; i++) begin
            if (p0_ack && a0 < 0) a0 = cyc - t;
            if (p1_ack && a1 < 0) a1 = cyc - t;
            if (a0 >= 0 && a1 >= 0) break;
            @(negedge clk);
         end
         first_port = (a1 >= 0 && (a0 < 0 || a1 < a0)) ? 1 : 0;
         check($sformatf("pair%0d first grant port", k), first_port, exp_first);
         check($sformatf("pair%0d first latency", k), first_port ? a1 : a0, 3 + D);
         check($sformatf("pair%0d second latency", k), first_port ? a0 : a1, 2 * (3 + D));
         @(negedge clk);
      end

      // Reset pulse during WAIT of a p0 read abandons it.
      t = cyc;
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1234);
      @(negedge clk);
      release_reqs();
      repeat (3) @(negedge clk);
      check("abort read issued", last_req_cyc - t, 2);
      rst = 1'b1;
      exp_q0.delete();
      @(negedge clk);
      rst = 1'b0;
      check("abort busy cleared", p0_busy, 0);
      for (int i = 0; i < 10; i++) begin
         check("abort no p0 ack", p0_ack, 0);
         @(negedge clk);
      end
      t = cyc;
      drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 32'hBEEF);
      @(negedge clk);
      release_reqs();
      wait_ack(1'b1, t, lat);
      check("post-abort p1 latency", lat, 3 + D);

      repeat (3) @(negedge clk);
      check("p0 scoreboard drained", exp_q0.size(), 0);
      check("p1 scoreboard drained", exp_q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
